// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and loads the IF/ID register.
// Optional performance counters are compiled in when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_flag,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] if_stall_cnt,
  output logic [31:0] if_wait_cnt,
  output logic [31:0] if_flush_cnt
`endif
);

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] saved_pc, saved_pc_nxt;
  logic [31:0] id_inst_nxt, id_pc_nxt;
  logic        id_valid_nxt;

  assign imem_req  = !rst;
  assign imem_addr = pc;
  // A word arriving for a fetch that is being thrown away must not trigger a hazard stall.
  assign if_inst   = (state == FETCH && imem_ready) ? imem_rdata : NOP_INST;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt    = state;
    pc_nxt       = pc;
    saved_pc_nxt = saved_pc;
    id_inst_nxt  = NOP_INST;
    id_pc_nxt    = id_pc;
    id_valid_nxt = 1'b0;

    if (ex_redirect) begin
      if (state == DISCARD) begin
        saved_pc_nxt = ex_redirect_pc;
      end else if (imem_ready) begin
        pc_nxt = ex_redirect_pc;
      end else begin
        // Keep the outstanding address on the bus until memory answers, then jump.
        saved_pc_nxt = ex_redirect_pc;
        state_nxt    = DISCARD;
      end
    end else if (state == DISCARD) begin
      if (imem_ready) begin
        pc_nxt    = saved_pc;
        state_nxt = FETCH;
      end
    end else if (imem_ready && !stall_flag) begin
      id_inst_nxt  = imem_rdata;
      id_pc_nxt    = pc;
      id_valid_nxt = 1'b1;
      pc_nxt       = pc + 32'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      saved_pc <= RESET_PC;
      id_inst  <= NOP_INST;
      id_pc    <= 32'h0000_0000;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      saved_pc <= saved_pc_nxt;
      id_inst  <= id_inst_nxt;
      id_pc    <= id_pc_nxt;
      id_valid <= id_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_stall_cnt <= 32'h0;
      if_wait_cnt  <= 32'h0;
      if_flush_cnt <= 32'h0;
    end else begin
      if (state == FETCH && imem_ready && stall_flag && !ex_redirect)
        if_stall_cnt <= if_stall_cnt + 32'd1;
      if (imem_req && !imem_ready)
        if_wait_cnt <= if_wait_cnt + 32'd1;
      if (ex_redirect)
        if_flush_cnt <= if_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
